// File: rtl/g_alu32_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : g_alu32_driver_if
//  Purpose  : Bundles the command channel, the response channel and the ALU
//             operand/result bus of the 32-bit ALU sequencing front-end.
//  Revision : 1.0 - initial release
// ============================================================================
interface g_alu32_driver_if;
   // Command channel
   logic        CmdValid;
   logic        CmdReady;
   logic [2:0]  CmdOp;
   logic        CmdWide;
   logic [63:0] CmdX;
   logic [63:0] CmdY;
   logic        CmdCI;
   // ALU side
   logic [31:0] AluIn1;
   logic [31:0] AluIn2;
   logic        AluCI;
   logic [2:0]  AluA;
   logic [31:0] AluOut;
   logic        AluCO;
   // Response channel
   logic        RspValid;
   logic        RspReady;
   logic [63:0] RspData;
   logic        RspCO;

   // The master is the environment around the driver: command source,
   // response consumer and the ALU itself.
   modport master (
      output CmdValid, CmdOp, CmdWide, CmdX, CmdY, CmdCI, RspReady, AluOut, AluCO,
      input  CmdReady, AluIn1, AluIn2, AluCI, AluA, RspValid, RspData, RspCO
   );

   // The slave is the driver.
   modport slave (
      input  CmdValid, CmdOp, CmdWide, CmdX, CmdY, CmdCI, RspReady, AluOut, AluCO,
      output CmdReady, AluIn1, AluIn2, AluCI, AluA, RspValid, RspData, RspCO
   );
endinterface
`default_nettype wire

// File: rtl/g_alu32_driver.sv
`default_nettype none
// ============================================================================
//  Module   : g_alu32_driver
//  Purpose  : Issues operations to the 32-bit ALU from registers, waits a
//             programmable settle time, captures the result and returns it on
//             a valid/ready channel. 64-bit operations run the ALU twice,
//             chaining the low-half carry into the high half for ADD.
//  Revision : 1.0 - initial release
// ============================================================================
module g_alu32_driver #(
   parameter int unsigned SETTLE = 0
) (
   input  logic            CLK,
   input  logic            RSTn,
   g_alu32_driver_if.slave bus
);

   localparam logic [2:0] OP_ADD     = 3'd4;
   localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t      state_q,     state_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic [2:0]  op_q,        op_d;
   logic        wide_q,      wide_d;
   logic [31:0] x_hi_q,      x_hi_d;
   logic [31:0] y_hi_q,      y_hi_d;
   logic [31:0] alu_in1_q,   alu_in1_d;
   logic [31:0] alu_in2_q,   alu_in2_d;
   logic        alu_ci_q,    alu_ci_d;
   logic [2:0]  alu_a_q,     alu_a_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [63:0] rsp_data_q,  rsp_data_d;
   logic        rsp_co_q,    rsp_co_d;

   logic        settle_done;
   logic        carry_capt;

   assign settle_done = (cnt_q == SETTLE_CNT);
   // Carry is only meaningful for ADD; other opcodes report zero.
   assign carry_capt  = (op_q == OP_ADD) && bus.AluCO;

   assign bus.CmdReady = (state_q == ST_IDLE);
   assign bus.AluIn1   = alu_in1_q;
   assign bus.AluIn2   = alu_in2_q;
   assign bus.AluCI    = alu_ci_q;
   assign bus.AluA     = alu_a_q;
   assign bus.RspValid = rsp_valid_q;
   assign bus.RspData  = rsp_data_q;
   assign bus.RspCO    = rsp_co_q;

   // Next-state and datapath update for the IDLE -> LO -> (HI) -> RESP sequence
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      wide_d      = wide_q;
      x_hi_d      = x_hi_q;
      y_hi_d      = y_hi_q;
      alu_in1_d   = alu_in1_q;
      alu_in2_d   = alu_in2_q;
      alu_ci_d    = alu_ci_q;
      alu_a_d     = alu_a_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_co_d    = rsp_co_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.CmdValid) begin
               // Low half goes straight to the ALU; the high half is kept
               // for a possible second pass.
               op_d      = bus.CmdOp;
               wide_d    = bus.CmdWide;
               x_hi_d    = bus.CmdX[63:32];
               y_hi_d    = bus.CmdY[63:32];
               alu_a_d   = bus.CmdOp;
               alu_in1_d = bus.CmdX[31:0];
               alu_in2_d = bus.CmdY[31:0];
               alu_ci_d  = (bus.CmdOp == OP_ADD) ? bus.CmdCI : 1'b0;
               cnt_d     = 4'd0;
               state_d   = ST_LO;
            end
         end

         ST_LO: begin
            if (settle_done) begin
               cnt_d             = 4'd0;
               rsp_data_d[31:0]  = bus.AluOut;
               if (wide_q) begin
                  // Low-half carry feeds the high-half pass directly.
                  alu_in1_d = x_hi_q;
                  alu_in2_d = y_hi_q;
                  alu_ci_d  = carry_capt;
                  state_d   = ST_HI;
               end else begin
                  rsp_data_d[63:32] = 32'd0;
                  rsp_co_d          = carry_capt;
                  rsp_valid_d       = 1'b1;
                  state_d           = ST_RESP;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_HI: begin
            if (settle_done) begin
               cnt_d             = 4'd0;
               rsp_data_d[63:32] = bus.AluOut;
               rsp_co_d          = carry_capt;
               rsp_valid_d       = 1'b1;
               state_d           = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_RESP: begin
            if (bus.RspReady) begin
               // Quiesce the ALU while idle.
               rsp_valid_d = 1'b0;
               alu_in1_d   = 32'd0;
               alu_in2_d   = 32'd0;
               alu_ci_d    = 1'b0;
               alu_a_d     = 3'd0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            rsp_valid_d = 1'b0;
            alu_in1_d   = 32'd0;
            alu_in2_d   = 32'd0;
            alu_ci_d    = 1'b0;
            alu_a_d     = 3'd0;
            cnt_d       = 4'd0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         op_q        <= 3'd0;
         wide_q      <= 1'b0;
         x_hi_q      <= 32'd0;
         y_hi_q      <= 32'd0;
         alu_in1_q   <= 32'd0;
         alu_in2_q   <= 32'd0;
         alu_ci_q    <= 1'b0;
         alu_a_q     <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 64'd0;
         rsp_co_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         wide_q      <= wide_d;
         x_hi_q      <= x_hi_d;
         y_hi_q      <= y_hi_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         alu_ci_q    <= alu_ci_d;
         alu_a_q     <= alu_a_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_co_q    <= rsp_co_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_g_alu32_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_g_alu32_driver
//  Purpose  : Self-checking bench for g_alu32_driver with a behavioural ALU
//             and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_g_alu32_driver;

   localparam int S = 2;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   always #5 CLK = ~CLK;

   g_alu32_driver_if bus ();
   g_alu32_driver_if bus0 ();

   g_alu32_driver #(.SETTLE(S)) u_dut  (.CLK(CLK), .RSTn(RSTn), .bus(bus.slave));
   g_alu32_driver #(.SETTLE(0)) u_dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0.slave));

   // Shared stimulus, steered to one DUT by sel (1 = SETTLE=2 DUT)
   logic        sel = 1'b1;
   logic        cmd_valid = 1'b0, rsp_ready = 1'b0, cmd_wide = 1'b0, cmd_ci = 1'b0;
   logic [2:0]  cmd_op = 3'd0;
   logic [63:0] cmd_x = 64'd0, cmd_y = 64'd0;

   assign bus.CmdValid  = sel & cmd_valid;
   assign bus0.CmdValid = ~sel & cmd_valid;
   assign bus.RspReady  = sel & rsp_ready;
   assign bus0.RspReady = ~sel & rsp_ready;
   assign bus.CmdOp  = cmd_op;  assign bus0.CmdOp  = cmd_op;
   assign bus.CmdWide = cmd_wide; assign bus0.CmdWide = cmd_wide;
   assign bus.CmdX   = cmd_x;   assign bus0.CmdX   = cmd_x;
   assign bus.CmdY   = cmd_y;   assign bus0.CmdY   = cmd_y;
   assign bus.CmdCI  = cmd_ci;  assign bus0.CmdCI  = cmd_ci;

   logic        m_cmd_ready, m_rsp_valid, m_rsp_co, m_alu_ci;
   logic [63:0] m_rsp_data;
   assign m_cmd_ready = sel ? bus.CmdReady : bus0.CmdReady;
   assign m_rsp_valid = sel ? bus.RspValid : bus0.RspValid;
   assign m_rsp_co    = sel ? bus.RspCO    : bus0.RspCO;
   assign m_alu_ci    = sel ? bus.AluCI    : bus0.AluCI;
   assign m_rsp_data  = sel ? bus.RspData  : bus0.RspData;

   // Behavioural ALU; non-ADD ops emit a junk carry so RspCO masking is visible
   function automatic logic [32:0] alu_f(input logic [2:0] a, input logic [31:0] p,
                                         input logic [31:0] q, input logic ci);
      logic g;
      g = ^(p ^ q);
      case (a)
         3'd0: return {g, p & q};
         3'd1: return {g, p | q};
         3'd2: return {g, p ^ q};
         3'd3: return {g, ~p};
         3'd4: return {1'b0, p} + {1'b0, q} + {32'd0, ci};
         3'd5: return {g, p << 1};
         3'd6: return {g, p >> 1};
         default: return {g, 16'd0, p[15:0]};
      endcase
   endfunction

   always_comb {bus.AluCO, bus.AluOut}   = alu_f(bus.AluA, bus.AluIn1, bus.AluIn2, bus.AluCI);
   always_comb {bus0.AluCO, bus0.AluOut} = alu_f(bus0.AluA, bus0.AluIn1, bus0.AluIn2, bus0.AluCI);

   // Expected {co, data}: wide ADD is a true 64-bit sum, other wide ops are per half
   function automatic logic [64:0] exp_rsp(input logic [2:0] op, input logic w,
                                           input logic [63:0] x, input logic [63:0] y,
                                           input logic ci);
      logic [64:0] s;
      logic [32:0] n, lo, hi;
      if (op == 3'd4) begin
         if (w) begin
            s = {1'b0, x} + {1'b0, y} + {64'd0, ci};
         end else begin
            n = {1'b0, x[31:0]} + {1'b0, y[31:0]} + {32'd0, ci};
            s = {n[32], 32'd0, n[31:0]};
         end
      end else begin
         lo = alu_f(op, x[31:0], y[31:0], 1'b0);
         hi = alu_f(op, x[63:32], y[63:32], 1'b0);
         s  = {1'b0, (w ? hi[31:0] : 32'd0), lo[31:0]};
      end
      return s;
   endfunction

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process for the SETTLE=2 DUT, evaluated on every falling edge
   logic        m_busy = 1'b0, m_wide = 1'b0, m_ci = 1'b0, m_clo = 1'b0, exp_v;
   logic [2:0]  m_op = 3'd0;
   logic [63:0] m_x = 64'd0, m_y = 64'd0;
   logic [64:0] m_exp = 65'd0;
   int          m_age = 0, m_lat = 0;

   always @(negedge CLK) begin
      if (!RSTn) begin
         chk("rst_status", 65'({bus.CmdReady, bus.RspValid, bus.RspCO}), 65'b100);
         chk("rst_data", 65'(bus.RspData), 65'd0);
         chk("rst_alu_in", 65'({bus.AluIn1, bus.AluIn2}), 65'd0);
         chk("rst_alu_ctl", 65'({bus.AluCI, bus.AluA}), 65'd0);
         m_busy = 1'b0;
      end else begin
         if (m_busy) m_age++;
         chk("cmd_ready", 65'(bus.CmdReady), 65'(!m_busy));
         if (!m_busy) begin
            chk("idle_alu_in", 65'({bus.AluIn1, bus.AluIn2}), 65'd0);
            chk("idle_alu_ctl", 65'({bus.AluCI, bus.AluA}), 65'd0);
         end else if (m_age <= S + 1) begin
            chk("lo_alu_in", 65'({bus.AluIn1, bus.AluIn2}), 65'({m_x[31:0], m_y[31:0]}));
            chk("lo_alu_ctl", 65'({bus.AluA, bus.AluCI}), 65'({m_op, (m_op == 3'd4) && m_ci}));
         end else if (m_wide && m_age <= 2 * S + 2) begin
            chk("hi_alu_in", 65'({bus.AluIn1, bus.AluIn2}), 65'({m_x[63:32], m_y[63:32]}));
            chk("hi_alu_ctl", 65'({bus.AluA, bus.AluCI}), 65'({m_op, (m_op == 3'd4) && m_clo}));
         end
         exp_v = m_busy && (m_age >= m_lat + 1);
         chk("rsp_valid", 65'(bus.RspValid), 65'(exp_v));
         if (exp_v) begin
            chk("rsp_data", 65'(bus.RspData), 65'(m_exp[63:0]));
            chk("rsp_co", 65'(bus.RspCO), 65'(m_exp[64]));
         end
         if (exp_v && bus.RspReady) begin
            m_busy = 1'b0;
         end else if (!m_busy && bus.CmdValid) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_op   = bus.CmdOp;
            m_wide = bus.CmdWide;
            m_x    = bus.CmdX;
            m_y    = bus.CmdY;
            m_ci   = bus.CmdCI;
            m_clo  = 1'(({1'b0, m_x[31:0]} + {1'b0, m_y[31:0]} + {32'd0, m_ci}) >> 32);
            m_exp  = exp_rsp(m_op, m_wide, m_x, m_y, m_ci);
            m_lat  = m_wide ? 2 * (S + 1) : S + 1;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input logic ci);
      int n = 0;
      cmd_op = op; cmd_wide = w; cmd_x = x; cmd_y = y; cmd_ci = ci; cmd_valid = 1'b1;
      while (!m_cmd_ready && n < 50) begin tick(); n++; end
      chk("send_ready", 65'(m_cmd_ready), 65'd1);
      tick();
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
      // Scramble the fields: the driver must not rely on them after accept
      cmd_x = {$urandom, $urandom}; cmd_y = {$urandom, $urandom};
      cmd_op = 3'($urandom); cmd_wide = 1'($urandom); cmd_ci = 1'($urandom);
   endtask

   task automatic wait_rsp(input logic [63:0] d, input logic co, input int lat, input logic ack);
      int n = 0;
      while (!m_rsp_valid && n < 64) begin tick(); n++; end
      chk("rsp_seen", 65'(m_rsp_valid), 65'd1);
      chk("latency", 65'(cyc - acc_cyc), 65'(lat));
      chk("data", 65'(m_rsp_data), 65'(d));
      chk("co", 65'(m_rsp_co), 65'(co));
      if (ack) begin rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; end
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 4))
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         1: return 64'd0;
         2: return 64'h0000_0000_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  t0;
      logic seen;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst0_status", 65'({bus0.CmdReady, bus0.RspValid, bus0.RspCO}), 65'b100);
      chk("rst0_data", 65'(bus0.RspData), 65'd0);
      RSTn = 1'b1;
      tick();

      // Hand-computed values pinning the reference model
      chk("pin_wide_add", exp_rsp(3'd4, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0),
          {1'b0, 64'h0000_0001_0000_0000});
      chk("pin_wide_xor", exp_rsp(3'd2, 1'b1, 64'hF0F0_F0F0_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0),
          {1'b0, 64'h0F0F_0F0F_F0F0_F0F0});

      // SETTLE=0 DUT: narrow and wide ADD
      sel = 1'b0;
      send(3'd4, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      chk("d0_lo_ci", 65'(m_alu_ci), 65'd0);
      wait_rsp(64'd0, 1'b1, 1, 1'b1);
      send(3'd4, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      chk("d0_wide_lo_ci", 65'(m_alu_ci), 65'd0);
      tick();
      chk("d0_wide_hi_ci", 65'(m_alu_ci), 65'd1);
      wait_rsp(64'h0000_0001_0000_0000, 1'b0, 2, 1'b1);

      // SETTLE=2 DUT
      sel = 1'b1;
      send(3'd2, 1'b1, 64'hF0F0_F0F0_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      wait_rsp(64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 6, 1'b1);

      // Backpressure with a competing command offered
      send(3'd4, 1'b0, 64'd5, 64'd7, 1'b1);
      wait_rsp(64'd13, 1'b0, 3, 1'b0);
      cmd_op = 3'd3; cmd_wide = 1'b0; cmd_x = 64'h0000_FFFF; cmd_y = 64'd0; cmd_valid = 1'b1;
      repeat (5) begin
         tick();
         chk("bp_valid", 65'(m_rsp_valid), 65'd1);
         chk("bp_data", 65'(m_rsp_data), 65'd13);
         chk("bp_co", 65'(m_rsp_co), 65'd0);
         chk("bp_cmd_ready", 65'(m_cmd_ready), 65'd0);
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      chk("bp_ready_after", 65'(m_cmd_ready), 65'd1);
      chk("bp_valid_after", 65'(m_rsp_valid), 65'd0);
      tick();
      acc_cyc = cyc; cmd_valid = 1'b0;
      wait_rsp(64'h0000_0000_FFFF_0000, 1'b0, 3, 1'b1);

      // Back-to-back narrow commands
      send(3'd3, 1'b0, 64'h0000_FFFF, 64'd0, 1'b0);
      wait_rsp(64'h0000_0000_FFFF_0000, 1'b0, 3, 1'b1);
      t0 = cyc;
      send(3'd0, 1'b0, 64'hFF00_FF00, 64'h0FF0_0FF0, 1'b0);
      chk("b2b_accept_delay", 65'(cyc - t0), 65'd1);
      wait_rsp(64'h0000_0000_0F00_0F00, 1'b0, 3, 1'b1);

      // Asynchronous reset during the high pass of a wide ADD
      send(3'd4, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      repeat (S + 1) tick();
      chk("pre_rst_hi_ci", 65'(m_alu_ci), 65'd1);
      #2 RSTn = 1'b0;
      #1;
      chk("arst_status", 65'({bus.CmdReady, bus.RspValid, bus.RspCO}), 65'b100);
      chk("arst_data", 65'(bus.RspData), 65'd0);
      chk("arst_alu_in", 65'({bus.AluIn1, bus.AluIn2}), 65'd0);
      chk("arst_alu_ctl", 65'({bus.AluCI, bus.AluA}), 65'd0);
      @(posedge CLK);
      #3 RSTn = 1'b1;
      seen = 1'b0;
      repeat (12) begin tick(); if (m_rsp_valid) seen = 1'b1; end
      chk("no_rsp_after_rst", 65'(seen), 65'd0);
      chk("ready_after_rst", 65'(m_cmd_ready), 65'd1);

      // Randomized traffic, checked by the compare process
      repeat (4000) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_op    = 3'($urandom);
         cmd_wide  = 1'($urandom);
         cmd_x     = pick();
         cmd_y     = pick();
         cmd_ci    = 1'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
